ddr_rd_stream: RTL and testbench

- Upstream feeder for the DDR-to-buffer loaders such as the accumulation/bias loader.
- On `start`, issues burst read requests to the memory controller for `conf_beat_num` beats from `conf_base_addr`.
- Buffers returned beats in an internal FIFO and presents them as the `ddr_data`/`ddr_valid`/`ddr_ready` stream consumed downstream.
- A credit scheme guarantees the FIFO never overflows, so the memory data channel is never back-pressured mid-burst.

---
 rtl/ddr_rd_stream_if.sv | 32 +++
 rtl/ddr_rd_stream.sv | 179 +++++++++++++++++
 tb/tb_ddr_rd_stream.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_stream_if
// Brief    : Memory read request/data channels plus the beat stream to loaders.
// Revision : 1.0
// ============================================================================
interface ddr_rd_stream_if #(
    parameter int DDR_W      = 64,
    parameter int MEM_ADDR_W = 32
);
    logic [MEM_ADDR_W-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic                  rd_addr_valid;
    logic                  rd_addr_ready;
    logic [DDR_W-1:0]      rd_data;
    logic                  rd_data_valid;
    logic                  rd_data_ready;
    logic [DDR_W-1:0]      ddr_data;
    logic                  ddr_valid;
    logic                  ddr_ready;

    modport master (
        output rd_addr, rd_len, rd_addr_valid, rd_data_ready, ddr_data, ddr_valid,
        input  rd_addr_ready, rd_data, rd_data_valid, ddr_ready
    );

    modport slave (
        input  rd_addr, rd_len, rd_addr_valid, rd_data_ready, ddr_data, ddr_valid,
        output rd_addr_ready, rd_data, rd_data_valid, ddr_ready
    );
endinterface
`default_nettype wire

// File: rtl/ddr_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_stream
// Brief    : Credit-limited burst reader feeding a beat FIFO and output stream.
// Revision : 1.0
// ============================================================================
module ddr_rd_stream #(
    parameter int DDR_W      = 64,
    parameter int MEM_ADDR_W = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int NUM_W      = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    output logic                       done,
    input  wire logic [MEM_ADDR_W-1:0] conf_base_addr,
    input  wire logic [NUM_W-1:0]      conf_beat_num,
    ddr_rd_stream_if.master            bus
);
    localparam int c_beat_shift = $clog2(DDR_W / 8);
    localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w      = c_ptr_w + 1;
    localparam int c_blen_w     = $clog2(BURST_LEN) + 1;
    localparam int c_sum_w      = c_cnt_w + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [NUM_W-1:0]        req_left_q, req_left_d;
    logic [NUM_W-1:0]        pop_left_q, pop_left_d;
    logic [MEM_ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [c_cnt_w-1:0]      outst_q, outst_d;
    logic [c_cnt_w-1:0]      count_q, count_d;
    logic [c_ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DDR_W-1:0]        fifo_mem [FIFO_DEPTH];

    logic [c_blen_w-1:0]     w_blen;
    logic [MEM_ADDR_W-1:0]   w_addr_step;
    logic [c_sum_w-1:0]      w_credit_sum;
    logic                    w_req_valid;
    logic                    w_hs;
    logic                    w_push;
    logic                    w_pop;

    always_comb begin
        w_blen = req_left_q[c_blen_w-1:0];
        if (req_left_q >= NUM_W'(BURST_LEN)) begin
            w_blen = c_blen_w'(BURST_LEN);
        end
    end

    // A burst is only requested when the FIFO is guaranteed room for every beat in flight.
    assign w_credit_sum = {2'b00, count_q} + {2'b00, outst_q} + c_sum_w'(w_blen);
    assign w_req_valid  = (state_q == ST_ISSUE) && (req_left_q != '0)
                          && (w_credit_sum <= c_sum_w'(FIFO_DEPTH));
    assign w_hs         = w_req_valid && bus.rd_addr_ready;
    assign w_push       = bus.rd_data_valid && (state_q != ST_IDLE);
    assign w_pop        = (count_q != '0) && bus.ddr_ready;
    assign w_addr_step  = MEM_ADDR_W'(w_blen) << c_beat_shift;

    assign bus.rd_addr_valid = w_req_valid;
    assign bus.rd_addr       = (state_q == ST_ISSUE) ? cur_addr_q : '0;
    assign bus.rd_len        = ((state_q == ST_ISSUE) && (req_left_q != '0))
                               ? (8'(w_blen) - 8'd1) : 8'd0;
    assign bus.rd_data_ready = 1'b1;
    assign bus.ddr_valid     = (count_q != '0);
    assign bus.ddr_data      = fifo_mem[rd_ptr_q];
    assign done              = done_q;

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        req_left_d = req_left_q;
        cur_addr_d = cur_addr_q;
        pop_left_d = pop_left_q;
        if (w_pop && (pop_left_q != '0)) begin
            pop_left_d = pop_left_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                done_d = 1'b1;
                if (start) begin
                    done_d = 1'b0;
                    if (conf_beat_num != '0) begin
                        state_d    = ST_ISSUE;
                        req_left_d = conf_beat_num;
                        pop_left_d = conf_beat_num;
                        cur_addr_d = conf_base_addr;
                    end
                end
            end
            ST_ISSUE: begin
                done_d = 1'b0;
                if (w_hs) begin
                    cur_addr_d = cur_addr_q + w_addr_step;
                    req_left_d = req_left_q - NUM_W'(w_blen);
                    if (req_left_d == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                done_d = 1'b0;
                if (pop_left_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    always_comb begin
        outst_d  = outst_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_hs) begin
            outst_d = outst_d + c_cnt_w'(w_blen);
        end
        if (w_push && ((outst_q != '0) || w_hs)) begin
            outst_d = outst_d - 1'b1;
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b1;
            req_left_q <= '0;
            pop_left_q <= '0;
            cur_addr_q <= '0;
            outst_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            req_left_q <= req_left_d;
            pop_left_q <= pop_left_d;
            cur_addr_q <= cur_addr_d;
            outst_q    <= outst_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= bus.rd_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rd_stream
// Brief    : Scoreboard bench with memory/loader models for ddr_rd_stream.
// Revision : 1.0
// ============================================================================
module tb_ddr_rd_stream;
    localparam int DDR_W = 64;
    localparam int AW    = 32;
    localparam int NW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] conf_base_addr = '0;
    logic [NW-1:0] conf_beat_num = '0;

    ddr_rd_stream_if #(.DDR_W(DDR_W), .MEM_ADDR_W(AW)) bus ();

    ddr_rd_stream #(
        .DDR_W(DDR_W), .MEM_ADDR_W(AW), .BURST_LEN(16), .FIFO_DEPTH(DEPTH), .NUM_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .conf_base_addr(conf_base_addr), .conf_beat_num(conf_beat_num), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_req_addr[$];
    logic [7:0]  exp_req_len[$];
    logic [63:0] exp_beat[$];
    logic [31:0] ret_q[$];

    int n_tests = 0, n_fail = 0;
    int req_total = 0, pop_total = 0, hs_cnt = 0, last_pop_cyc = 0;
    int model_occ = 0, max_occ = 0, max_ahead = 0;
    bit addr_rdy_en = 1'b1, ld_en = 1'b1, mem_slow = 1'b0, drop_mode = 1'b0;
    bit saw_req_v = 1'b0, saw_ddr_v = 1'b0;

    function automatic logic [63:0] mk_data(logic [31:0] a);
        return {a, a ^ 32'hDEAD_BEEF};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Memory controller, loader, and output monitor share one negedge-aligned loop.
    initial begin
        logic [31:0] ea;
        logic [7:0]  el;
        logic [63:0] eb;
        bus.rd_addr_ready = 1'b0;
        bus.rd_data       = '0;
        bus.rd_data_valid = 1'b0;
        bus.ddr_ready     = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_addr_ready = addr_rdy_en;
            bus.ddr_ready     = ld_en;
            if (ret_q.size() > 0 && (!mem_slow || cyc[0])) begin
                bus.rd_data_valid = 1'b1;
                bus.rd_data       = mk_data(ret_q[0]);
            end else begin
                bus.rd_data_valid = 1'b0;
                bus.rd_data       = '0;
            end
            #1;
            if (rst) begin
                if (bus.rd_addr_valid) saw_req_v = 1'b1;
                if (bus.ddr_valid) saw_ddr_v = 1'b1;
                if (bus.rd_addr_valid && bus.rd_addr_ready) begin
                    hs_cnt++;
                    req_total += int'(bus.rd_len) + 1;
                    for (int i = 0; i <= int'(bus.rd_len); i++)
                        ret_q.push_back(bus.rd_addr + 32'(i * 8));
                    if (exp_req_addr.size() == 0) begin
                        fail_now("req_unexpected");
                    end else begin
                        ea = exp_req_addr.pop_front();
                        el = exp_req_len.pop_front();
                        check("req_addr", 64'(bus.rd_addr), 64'(ea));
                        check("req_len", 64'(bus.rd_len), 64'(el));
                    end
                end
                if (bus.rd_data_valid && bus.rd_data_ready) begin
                    void'(ret_q.pop_front());
                    if (!drop_mode) model_occ++;
                end
                if (bus.ddr_valid && bus.ddr_ready) begin
                    pop_total++;
                    model_occ--;
                    last_pop_cyc = cyc;
                    if (exp_beat.size() == 0) begin
                        fail_now("beat_unexpected");
                    end else begin
                        eb = exp_beat.pop_front();
                        check("beat_data", bus.ddr_data, eb);
                    end
                end
                if (model_occ > max_occ) max_occ = model_occ;
                if (req_total - pop_total > max_ahead) max_ahead = req_total - pop_total;
            end
        end
    end

    task automatic clear_stats();
        req_total = 0; pop_total = 0; hs_cnt = 0; max_occ = 0; max_ahead = 0;
        saw_req_v = 1'b0; saw_ddr_v = 1'b0;
    endtask

    task automatic expect_beats(logic [31:0] base, int num);
        for (int i = 0; i < num; i++) exp_beat.push_back(mk_data(base + 32'(i * 8)));
    endtask

    task automatic expect_req(logic [31:0] a, logic [7:0] l);
        exp_req_addr.push_back(a);
        exp_req_len.push_back(l);
    endtask

    task automatic do_start(logic [31:0] base, logic [15:0] num);
        @(negedge clk);
        conf_base_addr = base;
        conf_beat_num  = num;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("done_low_after_start", 64'(done), 64'd0);
    endtask

    task automatic wait_done(string name, int max_cyc);
        bit ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            #2;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now({name, "_done_timeout"});
        else check({name, "_done_cycle"}, 64'(cyc), 64'(last_pop_cyc + 1));
    endtask

    task automatic end_checks(string name);
        check({name, "_beats_left"}, 64'(exp_beat.size()), 64'd0);
        check({name, "_reqs_left"}, 64'(exp_req_addr.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        #2;
        check("rst_done", 64'(done), 64'd1);
        check("rst_addr_valid", 64'(bus.rd_addr_valid), 64'd0);
        check("rst_addr", 64'(bus.rd_addr), 64'd0);
        check("rst_len", 64'(bus.rd_len), 64'd0);
        check("rst_ddr_valid", 64'(bus.ddr_valid), 64'd0);
        check("rst_data_ready", 64'(bus.rd_data_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Basic fetch
        clear_stats();
        expect_req(32'h1000, 8'd15); expect_req(32'h1080, 8'd15); expect_req(32'h1100, 8'd7);
        expect_beats(32'h1000, 40);
        do_start(32'h1000, 16'd40);
        wait_done("basic", 300);
        end_checks("basic");
        check("basic_pops", 64'(pop_total), 64'd40);

        // Back-pressure
        clear_stats();
        ld_en = 1'b0;
        for (int i = 0; i < 6; i++) expect_req(32'(i * 32'h80), 8'd15);
        expect_req(32'h300, 8'd3);
        expect_beats(32'h0, 100);
        do_start(32'h0, 16'd100);
        repeat (200) @(negedge clk);
        #2;
        check("bp_requested", 64'(req_total), 64'd64);
        check("bp_addr_valid", 64'(bus.rd_addr_valid), 64'd0);
        check("bp_ddr_valid", 64'(bus.ddr_valid), 64'd1);
        check("bp_data_hold", bus.ddr_data, mk_data(32'h0));
        ld_en = 1'b1;
        wait_done("bp", 600);
        end_checks("bp");
        check("bp_max_ahead", 64'(max_ahead), 64'd64);
        check("bp_max_occ", 64'(max_occ), 64'd64);

        // Address stall
        clear_stats();
        addr_rdy_en = 1'b0;
        expect_req(32'h2000, 8'd15);
        expect_beats(32'h2000, 16);
        do_start(32'h2000, 16'd16);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 64'(bus.rd_addr_valid), 64'd1);
            check("stall_addr", 64'(bus.rd_addr), 64'h2000);
            check("stall_len", 64'(bus.rd_len), 64'd15);
            @(negedge clk);
            #2;
        end
        check("stall_no_hs", 64'(hs_cnt), 64'd0);
        addr_rdy_en = 1'b1;
        wait_done("stall", 300);
        check("stall_one_hs", 64'(hs_cnt), 64'd1);
        end_checks("stall");

        // Zero length
        clear_stats();
        do_start(32'h5000, 16'd0);
        @(negedge clk);
        #2;
        check("zero_done_back", 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        #2;
        check("zero_no_req", 64'(saw_req_v), 64'd0);
        check("zero_no_ddr", 64'(saw_ddr_v), 64'd0);

        // Mid-transfer reset with a slow memory so beats are still in flight
        clear_stats();
        mem_slow = 1'b1;
        expect_req(32'h1000, 8'd15); expect_req(32'h1080, 8'd15); expect_req(32'h1100, 8'd7);
        expect_beats(32'h1000, 40);
        do_start(32'h1000, 16'd40);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pop_total >= 20) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("mid_rst_pop_timeout");
        rst = 1'b0;
        exp_beat.delete();
        exp_req_addr.delete();
        exp_req_len.delete();
        model_occ = 0;
        drop_mode = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("mid_rst_done", 64'(done), 64'd1);
        check("mid_rst_ddr_valid", 64'(bus.ddr_valid), 64'd0);
        check("mid_rst_addr_valid", 64'(bus.rd_addr_valid), 64'd0);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ret_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
        if (!ok) fail_now("mid_rst_stale_timeout");
        @(negedge clk);
        #2;
        check("mid_rst_stale_dropped", 64'(bus.ddr_valid), 64'd0);
        mem_slow = 1'b0;
        drop_mode = 1'b0;
        clear_stats();
        expect_req(32'h4000, 8'd7);
        expect_beats(32'h4000, 8);
        do_start(32'h4000, 16'd8);
        wait_done("after_rst", 200);
        end_checks("after_rst");

        // Start while busy: the second pulse lands during ISSUE
        clear_stats();
        expect_req(32'h3000, 8'd15); expect_req(32'h3080, 8'd7);
        expect_beats(32'h3000, 24);
        @(negedge clk);
        conf_base_addr = 32'h3000;
        conf_beat_num  = 16'd24;
        start = 1'b1;
        @(negedge clk);
        conf_base_addr = 32'h9000;
        conf_beat_num  = 16'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("busy_done_low", 64'(done), 64'd0);
        wait_done("busy", 300);
        end_checks("busy");
        check("busy_pops", 64'(pop_total), 64'd24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
